// File: rtl/icache_sa.sv
// Set-associative instruction cache with AXI4 read-only refill.
// Hits answer in the request cycle; misses fetch a full line with a
// critical-word-first WRAP burst, except in the uncached window, where a
// single-beat fetch is made and nothing is stored.
module icache_sa #(
    parameter int          WIDTH      = 32,
    parameter int          WAYS       = 2,
    parameter int          SETS       = 4,
    parameter int          LINE_WORDS = 4,
    parameter logic [15:0] UNCACHE_HI = 16'h0f00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             rreq_i,
    input  logic [WIDTH-1:0] raddr_i,
    output logic             rready_o,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rerr_o,
    input  logic             icache_arready_i,
    output logic             icache_arvalid_o,
    output logic [WIDTH-1:0] icache_araddr_o,
    output logic [7:0]       icache_arlen_o,
    output logic [2:0]       icache_arsize_o,
    output logic [1:0]       icache_arburst_o,
    input  logic             icache_rvalid_i,
    input  logic [WIDTH-1:0] icache_rdata_i,
    input  logic [1:0]       icache_rresp_i,
    input  logic             icache_rlast_i,
    output logic             icache_rready_o
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_LO = OFF_W + IDX_W + 2;
    localparam int TAG_W  = WIDTH - TAG_LO;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t                    state_reg, state_next;
    logic                      flush_pend_reg, flush_pend_next;
    logic                      line_err_reg, line_err_next;
    logic                      first_beat_reg, first_beat_next;
    logic                      uncached_reg, uncached_next;
    logic [WIDTH-1:0]          miss_addr_reg, miss_addr_next;
    logic [OFF_W-1:0]          fill_ptr_reg, fill_ptr_next;
    logic [WAY_W-1:0]          victim_reg, victim_next;
    logic [WAYS-1:0][SETS-1:0] valid_reg, valid_next;
    logic [SETS-1:0][WAY_W-1:0] rr_ptr_reg, rr_ptr_next;

    // Tag and data storage; reads are combinational so hits return same cycle
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [WIDTH-1:0] data_mem [WAYS][SETS*LINE_WORDS];

    // Request and miss address fields
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_uncached;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;

    assign req_off      = raddr_i[OFF_W+1:2];
    assign req_idx      = raddr_i[TAG_LO-1:OFF_W+2];
    assign req_tag      = raddr_i[WIDTH-1:TAG_LO];
    assign req_uncached = (raddr_i[WIDTH-1 -: 16] == UNCACHE_HI);
    assign miss_idx     = miss_addr_reg[TAG_LO-1:OFF_W+2];
    assign miss_tag     = miss_addr_reg[WIDTH-1:TAG_LO];

    // Byte-lane bits and the OKAY/EXOKAY distinction carry no information here
    logic unused_bits;
    assign unused_bits = ^{raddr_i[1:0], icache_rresp_i[0]};

    // Per-way tag compare; uncached addresses never hit
    logic [WAYS-1:0] way_hit;
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way_hit
            assign way_hit[gi] = valid_reg[gi][req_idx] && !req_uncached &&
                                 (tag_mem[gi][req_idx] == req_tag);
        end
    endgenerate

    logic             accept, hit_any, beat, beat_err, fill_write, install;
    logic [WAY_W-1:0] hit_way, miss_victim;
    logic [WIDTH-1:0] hit_word;

    assign accept     = rready_o && rreq_i;
    assign hit_any    = |way_hit;
    assign hit_word   = data_mem[hit_way][{req_idx, req_off}];
    assign beat       = (state_reg == WAIT) && icache_rvalid_i;
    assign beat_err   = icache_rresp_i[1];
    assign fill_write = beat && !uncached_reg && !beat_err;
    assign install    = beat && icache_rlast_i && !uncached_reg &&
                        !line_err_reg && !beat_err;

    // Hit-way encode and victim choice: lowest invalid way wins, else round-robin
    always_comb begin
        hit_way     = '0;
        miss_victim = rr_ptr_reg[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid_reg[w][req_idx]) begin
                miss_victim = WAY_W'(w);
            end
        end
    end

    // Next-state and output decode for the IDLE/SEND/WAIT controller
    always_comb begin
        state_next       = state_reg;
        flush_pend_next  = flush_pend_reg;
        line_err_next    = line_err_reg;
        first_beat_next  = first_beat_reg;
        uncached_next    = uncached_reg;
        miss_addr_next   = miss_addr_reg;
        fill_ptr_next    = fill_ptr_reg;
        victim_next      = victim_reg;
        valid_next       = valid_reg;
        rr_ptr_next      = rr_ptr_reg;
        rready_o         = reset && (state_reg == IDLE) && !flush_pend_reg;
        rvalid_o         = 1'b0;
        rdata_o          = '0;
        rerr_o           = 1'b0;
        icache_arvalid_o = (state_reg == SEND);
        icache_araddr_o  = miss_addr_reg;
        icache_arlen_o   = uncached_reg ? 8'd0 : 8'(LINE_WORDS - 1);
        icache_arsize_o  = 3'b010;
        icache_arburst_o = uncached_reg ? 2'b00 : 2'b10;
        icache_rready_o  = (state_reg == WAIT);

        case (state_reg)
            IDLE: begin
                if (flush_pend_reg) begin
                    valid_next      = '0;
                    flush_pend_next = 1'b0;
                end else if (accept && hit_any) begin
                    rvalid_o = 1'b1;
                    rdata_o  = hit_word;
                end else if (accept) begin
                    miss_addr_next  = raddr_i;
                    fill_ptr_next   = req_off;
                    victim_next     = miss_victim;
                    uncached_next   = req_uncached;
                    line_err_next   = 1'b0;
                    first_beat_next = 1'b1;
                    state_next      = SEND;
                    // The victim's data is overwritten beat by beat, so it must
                    // stop hitting now rather than at the end of the burst.
                    if (!req_uncached) begin
                        valid_next[miss_victim][req_idx] = 1'b0;
                    end
                end
            end
            SEND: begin
                if (icache_arready_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (beat) begin
                    if (first_beat_reg) begin
                        rvalid_o = 1'b1;
                        rdata_o  = icache_rdata_i;
                        rerr_o   = beat_err;
                    end
                    first_beat_next = 1'b0;
                    fill_ptr_next   = fill_ptr_reg + 1'b1;
                    if (beat_err) begin
                        line_err_next = 1'b1;
                    end
                    if (icache_rlast_i) begin
                        state_next = IDLE;
                    end
                    if (install) begin
                        valid_next[victim_reg][miss_idx] = 1'b1;
                        rr_ptr_next[miss_idx] =
                            (rr_ptr_reg[miss_idx] == WAY_W'(WAYS - 1)) ? '0
                                                 : rr_ptr_reg[miss_idx] + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A new flush request is remembered in every state
        if (flush_i) begin
            flush_pend_next = 1'b1;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            flush_pend_reg <= 1'b0;
            line_err_reg   <= 1'b0;
            first_beat_reg <= 1'b0;
            uncached_reg   <= 1'b0;
            miss_addr_reg  <= '0;
            fill_ptr_reg   <= '0;
            victim_reg     <= '0;
            valid_reg      <= '0;
            rr_ptr_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            flush_pend_reg <= flush_pend_next;
            line_err_reg   <= line_err_next;
            first_beat_reg <= first_beat_next;
            uncached_reg   <= uncached_next;
            miss_addr_reg  <= miss_addr_next;
            fill_ptr_reg   <= fill_ptr_next;
            victim_reg     <= victim_next;
            valid_reg      <= valid_next;
            rr_ptr_reg     <= rr_ptr_next;
        end
    end

    // Array writes: data per good beat, tag once the whole line arrived cleanly
    always_ff @(posedge clock) begin
        if (fill_write) begin
            data_mem[victim_reg][{miss_idx, fill_ptr_reg}] <= icache_rdata_i;
        end
        if (install) begin
            tag_mem[victim_reg][miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed self-checking bench for icache_sa with default parameters.
// Line data used for refills is base + word_index so every word is distinct.
module tb_icache_sa;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush_i = 1'b0;
    logic        rreq_i = 1'b0;
    logic [31:0] raddr_i = '0;
    logic        rready_o, rvalid_o, rerr_o;
    logic [31:0] rdata_o;
    logic        icache_arready_i = 1'b0;
    logic        icache_arvalid_o;
    logic [31:0] icache_araddr_o;
    logic [7:0]  icache_arlen_o;
    logic [2:0]  icache_arsize_o;
    logic [1:0]  icache_arburst_o;
    logic        icache_rvalid_i = 1'b0;
    logic [31:0] icache_rdata_i = '0;
    logic [1:0]  icache_rresp_i = '0;
    logic        icache_rlast_i = 1'b0;
    logic        icache_rready_o;

    int n_checks = 0;
    int n_fail   = 0;

    icache_sa dut (
        .clock            (clock),
        .reset            (reset),
        .flush_i          (flush_i),
        .rreq_i           (rreq_i),
        .raddr_i          (raddr_i),
        .rready_o         (rready_o),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .rerr_o           (rerr_o),
        .icache_arready_i (icache_arready_i),
        .icache_arvalid_o (icache_arvalid_o),
        .icache_araddr_o  (icache_araddr_o),
        .icache_arlen_o   (icache_arlen_o),
        .icache_arsize_o  (icache_arsize_o),
        .icache_arburst_o (icache_arburst_o),
        .icache_rvalid_i  (icache_rvalid_i),
        .icache_rdata_i   (icache_rdata_i),
        .icache_rresp_i   (icache_rresp_i),
        .icache_rlast_i   (icache_rlast_i),
        .icache_rready_o  (icache_rready_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All outputs that must be quiet while reset is held
    task automatic check_reset_outputs(input string tag);
        check({tag, ":rready"}, 32'(rready_o), 32'd0);
        check({tag, ":rvalid"}, 32'(rvalid_o), 32'd0);
        check({tag, ":rerr"}, 32'(rerr_o), 32'd0);
        check({tag, ":arvalid"}, 32'(icache_arvalid_o), 32'd0);
        check({tag, ":axi_rready"}, 32'(icache_rready_o), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check({tag, ":rready_after"}, 32'(rready_o), 32'd1);
        $display("reset %s", tag);
    endtask

    // Expect a same-cycle hit returning exp
    task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clock);
        rreq_i  = 1'b1;
        raddr_i = addr;
        #1;
        check({tag, ":hit_rvalid"}, 32'(rvalid_o), 32'd1);
        check({tag, ":hit_rdata"}, rdata_o, exp);
        check({tag, ":hit_rerr"}, 32'(rerr_o), 32'd0);
        @(negedge clock);
        rreq_i = 1'b0;
        #1;
        check({tag, ":stay_idle"}, 32'(rready_o), 32'd1);
        $display("hit  %s addr=%h data=%h", tag, addr, rdata_o);
    endtask

    // Expect a miss and serve the refill. Beat k carries word (off+k)%4 as
    // base+word; err_beat gets SLVERR; flush_beat pulses flush_i (-1 = none).
    task automatic fetch_miss(input string tag, input logic [31:0] addr, input logic [31:0] base,
                              input int nbeats, input logic [1:0] burst,
                              input int err_beat, input int flush_beat);
        int n;
        int word;
        @(negedge clock);
        rreq_i  = 1'b1;
        raddr_i = addr;
        #1;
        check({tag, ":req_rready"}, 32'(rready_o), 32'd1);
        check({tag, ":miss_rvalid"}, 32'(rvalid_o), 32'd0);
        @(negedge clock);
        rreq_i = 1'b0;
        #1;
        n = 0;
        while (icache_arvalid_o !== 1'b1 && n < 8) begin
            @(negedge clock);
            #1;
            n++;
        end
        check({tag, ":arvalid"}, 32'(icache_arvalid_o), 32'd1);
        check({tag, ":araddr"}, icache_araddr_o, addr);
        check({tag, ":arlen"}, 32'(icache_arlen_o), 32'(nbeats - 1));
        check({tag, ":arburst"}, 32'(icache_arburst_o), 32'(burst));
        check({tag, ":arsize"}, 32'(icache_arsize_o), 32'd2);
        check({tag, ":busy_rready"}, 32'(rready_o), 32'd0);
        @(negedge clock);
        #1;
        check({tag, ":arvalid_held"}, 32'(icache_arvalid_o), 32'd1);
        icache_arready_i = 1'b1;
        @(negedge clock);
        icache_arready_i = 1'b0;
        #1;
        check({tag, ":axi_rready"}, 32'(icache_rready_o), 32'd1);
        for (int k = 0; k < nbeats; k++) begin
            word            = (int'(addr[3:2]) + k) % 4;
            icache_rvalid_i = 1'b1;
            icache_rdata_i  = base + 32'(word);
            icache_rresp_i  = (k == err_beat) ? 2'b10 : 2'b00;
            icache_rlast_i  = (k == nbeats - 1);
            flush_i         = (k == flush_beat);
            #1;
            if (k == 0) begin
                check({tag, ":first_rvalid"}, 32'(rvalid_o), 32'd1);
                check({tag, ":first_rdata"}, rdata_o, base + 32'(word));
                check({tag, ":first_rerr"}, 32'(rerr_o), 32'(err_beat == 0));
            end else begin
                check({tag, ":later_rvalid"}, 32'(rvalid_o), 32'd0);
            end
            @(negedge clock);
        end
        icache_rvalid_i = 1'b0;
        icache_rlast_i  = 1'b0;
        icache_rresp_i  = 2'b00;
        flush_i         = 1'b0;
        #1;
        $display("miss %s addr=%h beats=%0d", tag, addr, nbeats);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("por:rready_after", 32'(rready_o), 32'd1);

        // Cold WRAP fetch, critical word first, then hits on the new line
        fetch_miss("cold", 32'h3000_0008, 32'hA000_0000, 4, 2'b10, -1, -1);
        fetch_hit("cold_w0", 32'h3000_0000, 32'hA000_0000);
        fetch_hit("cold_w3", 32'h3000_000C, 32'hA000_0003);

        // Three lines on index 0: third install evicts way 0
        do_reset("pre_evict");
        fetch_miss("l100", 32'h0000_0100, 32'h0000_1000, 4, 2'b10, -1, -1);
        fetch_hit("l100_hit", 32'h0000_0108, 32'h0000_1002);
        fetch_miss("l200", 32'h0000_0200, 32'h0000_2000, 4, 2'b10, -1, -1);
        fetch_miss("l300", 32'h0000_0300, 32'h0000_3000, 4, 2'b10, -1, -1);
        fetch_hit("l200_keep", 32'h0000_0200, 32'h0000_2000);
        fetch_hit("l300_hit", 32'h0000_0304, 32'h0000_3001);
        fetch_miss("l100_gone", 32'h0000_0100, 32'h0000_1000, 4, 2'b10, -1, -1);

        // Uncached single beat; repeat must go to the bus again
        fetch_miss("unc1", 32'h0F00_0004, 32'h5500_0000, 1, 2'b00, -1, -1);
        fetch_miss("unc2", 32'h0F00_0004, 32'h6600_0000, 1, 2'b00, -1, -1);

        // Error on the last beat keeps the line out of the cache
        fetch_miss("err", 32'h0000_0050, 32'h0000_5000, 4, 2'b10, 3, -1);
        fetch_miss("err_again", 32'h0000_0050, 32'h0000_7000, 4, 2'b10, -1, -1);
        fetch_hit("err_fixed", 32'h0000_0058, 32'h0000_7002);

        // Flush during refill: one blocked IDLE cycle, then nothing hits
        fetch_miss("flush", 32'h0000_0064, 32'h0000_6400, 4, 2'b10, -1, 1);
        check("flush:blocked", 32'(rready_o), 32'd0);
        @(negedge clock);
        #1;
        check("flush:reopen", 32'(rready_o), 32'd1);
        fetch_miss("flush_l300", 32'h0000_0300, 32'h0000_3300, 4, 2'b10, -1, -1);
        fetch_miss("flush_l64", 32'h0000_0064, 32'h0000_6400, 4, 2'b10, -1, -1);
        fetch_hit("flush_l64_hit", 32'h0000_006C, 32'h0000_6403);

        // Reset during the third beat of a refill
        @(negedge clock);
        rreq_i  = 1'b1;
        raddr_i = 32'h0000_00A0;
        @(negedge clock);
        rreq_i = 1'b0;
        #1;
        check("rst_mid:arvalid", 32'(icache_arvalid_o), 32'd1);
        icache_arready_i = 1'b1;
        @(negedge clock);
        icache_arready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            icache_rvalid_i = 1'b1;
            icache_rdata_i  = 32'h0000_D000 + 32'(k);
            @(negedge clock);
        end
        icache_rdata_i = 32'h0000_D002;
        reset          = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clock);
        icache_rvalid_i = 1'b0;
        reset           = 1'b1;
        #1;
        check("rst_mid:rready_after", 32'(rready_o), 32'd1);
        $display("reset rst_mid during refill");
        fetch_miss("rst_refetch", 32'h0000_00A0, 32'h0000_E000, 4, 2'b10, -1, -1);
        fetch_hit("rst_refetch_hit", 32'h0000_00A4, 32'h0000_E001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 Parameter WIDTH, 32, address/data width in bits.
REQ-002 Parameter WAYS, 2, associativity; power of two, 1..8.
REQ-003 Parameter SETS, 4, sets per way; power of two, >=2.
REQ-004 Parameter LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.
REQ-005 Parameter UNCACHE_HI, 16'h0f00, addr[31:16] value marking the uncached region.
REQ-006 clock  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 flush_i  input  1  invalidate-all request (fence.i).
REQ-009 rreq_i / raddr_i[WIDTH-1:0]  input  fetch request / word-aligned address.
REQ-010 rready_o  output  1  cache accepts rreq_i this cycle.
REQ-011 rvalid_o / rdata_o[WIDTH-1:0] / rerr_o  output  response valid / instruction / bus error.
REQ-012 AXI AR: icache_arready_i in; icache_arvalid_o, icache_araddr_o[WIDTH-1:0], icache_arlen_o[7:0], icache_arsize_o[2:0], icache_arburst_o[1:0] out.
REQ-013 AXI R: icache_rvalid_i, icache_rdata_i[WIDTH-1:0], icache_rresp_i[1:0], icache_rlast_i in; icache_rready_o out.

Function
REQ-014 Address split: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-015 States IDLE, SEND, WAIT; IDLE->SEND on accepted miss; SEND->WAIT on arvalid&&arready; WAIT->IDLE on rvalid&&rlast; otherwise hold.
REQ-016 rready_o = (state==IDLE) && !flush_pend; rreq_i while rready_o=0 is ignored.
REQ-017 Hit = accepted rreq_i && valid && tag match in any way of the indexed set; rvalid_o=1, rdata_o=hit word, rerr_o=0 in the same cycle, state stays IDLE.
REQ-018 Miss: raddr_i latched into miss register; state SEND next cycle.
REQ-019 SEND: arvalid_o=1, araddr_o=miss address, arsize_o=3'b010; cached: arlen_o=LINE_WORDS-1, arburst_o=2'b10 (WRAP); uncached: arlen_o=0, arburst_o=2'b00.
REQ-020 WAIT: icache_rready_o=1; fill pointer starts at miss offset, increments per beat, wraps modulo LINE_WORDS.
REQ-021 Critical-word-first: the first R beat returns rvalid_o=1, rdata_o=icache_rdata_i, rerr_o=(rresp is SLVERR/DECERR); later beats produce no response.
REQ-022 Cached beats with OKAY/EXOKAY write the victim way at the fill pointer; any error beat sets a line-error flag.
REQ-023 On rlast: if cached and line-error clear, write tag, set valid, update replacement; else leave tag/valid unchanged.
REQ-024 Victim = lowest-numbered invalid way, else per-set round-robin pointer; pointer advances (mod WAYS) only on installation.
REQ-025 flush_i in any state sets flush_pend; in IDLE with flush_pend, all valid bits clear in one cycle, flush_pend clears, no request accepted that cycle.
REQ-026 Flush during SEND/WAIT: refill completes and installs, then is invalidated on the first IDLE cycle.
REQ-027 Uncached responses never modify arrays; a repeat uncached fetch always misses.
REQ-028 rvalid_o=0 whenever not produced by REQ-017/REQ-021; arvalid_o held until arready (no retraction).

Reset
REQ-029 reset low asynchronously forces IDLE, all valid bits 0, round-robin pointers 0, flush_pend 0, line-error 0.
REQ-030 During reset: rready_o=0, rvalid_o=0, rerr_o=0, arvalid_o=0, icache_rready_o=0; rready_o=1 first cycle after release.
REQ-031 Reset mid-refill discards the refill; tag/data arrays need no reset.

Verification
REQ-032 Cold fetch 0x3000_0008 (defaults): AR araddr=0x3000_0008, arlen=3, burst=WRAP; beats D2,D3,D0,D1 -> rvalid with D2 on first beat; refetch 0x3000_0000 hits same cycle returning D0.
REQ-033 Three lines mapping to index 0 (0x100, 0x200, 0x300): third miss evicts way 0 (0x100); 0x200 still hits, 0x100 misses.
REQ-034 Fetch 0x0F00_0004: arlen=0, burst=00, single beat returned; second fetch issues new AR.
REQ-035 Refill with SLVERR on beat 3 -> first-beat rvalid rerr_o=0, line not installed, refetch misses.
REQ-036 flush_i during WAIT -> rready_o stays 0 one extra IDLE cycle, then all prior lines miss.
REQ-037 reset asserted during WAIT beat 2 -> outputs zero immediately; after release same address misses and re-issues AR.
